// File: rtl/sid_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sid_sched_pkg                                             |
// | Purpose  : Shared types and constants for the SID write scheduler:   |
// |            command-queue entry layout and host byte-decode fields.   |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package sid_sched_pkg;

  // Kind of queued command.
  typedef enum logic {
    ENT_WRITE = 1'b0,
    ENT_DELAY = 1'b1
  } entry_type_t;

  // One queued command. A DELAY keeps its count N in data[5:0].
  typedef struct packed {
    entry_type_t etype;
    logic [4:0]  addr;
    logic [7:0]  data;
  } entry_t;

  localparam int c_entry_w = $bits(entry_t);

  // Host byte layout: bit 7 set = address/MSB byte, else bit 6 set = delay.
  localparam int c_op_addr_bit  = 7;
  localparam int c_op_delay_bit = 6;

endpackage : sid_sched_pkg
`default_nettype wire

// File: rtl/sid_cmd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sid_cmd_fifo                                              |
// | Purpose  : Synchronous first-word-fall-through command FIFO with     |
// |            flush. A push while full is accepted when a pop happens   |
// |            in the same clock.                                        |
// | Ports    : clk, rstN (async, active-low), push/wdata, pop/rdata,     |
// |            flush, level, full, empty                                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module sid_cmd_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_level;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_level == '0);
  assign full      = (r_level == (c_aw+1)'(DEPTH));
  assign level     = r_level;
  assign rdata     = r_mem[r_rd_ptr];

  assign w_do_pop  = pop && !empty;
  // The slot freed by a same-clock pop makes room for the push.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_aw'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_aw'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + (c_aw+1)'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_level <= r_level - (c_aw+1)'(1);
      end
    end
  end

endmodule : sid_cmd_fifo
`default_nettype wire

// File: rtl/sid_write_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sid_write_sched                                           |
// | Purpose  : Decodes SPI host bytes into SID register writes and       |
// |            delays, queues them, and replays them onto the SID bus    |
// |            on 1 MHz clkEn ticks (at most one write per tick).        |
// | Ports    : clk, rstN (async, active-low), clkEn                      |
// |            iByte/iByteValid  host byte stream                        |
// |            iFlush, iClrOvf   queue flush, overflow clear             |
// |            oWE/oAddr/oDataW  SID write bus                           |
// |            oLevel/oFull/oEmpty/oOverflow/oBusy  status               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module sid_write_sched
  import sid_sched_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DELAY_UNIT = 64,
  parameter int CNT_W      = 13
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   clkEn,
  input  logic [7:0]             iByte,
  input  logic                   iByteValid,
  input  logic                   iFlush,
  input  logic                   iClrOvf,
  output logic                   oWE,
  output logic [4:0]             oAddr,
  output logic [7:0]             oDataW,
  output logic [$clog2(DEPTH):0] oLevel,
  output logic                   oFull,
  output logic                   oEmpty,
  output logic                   oOverflow,
  output logic                   oBusy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t               r_state;
  logic [4:0]           r_lat_addr;
  logic [1:0]           r_lat_msb;
  logic [CNT_W-1:0]     r_cnt;
  entry_t               w_push_entry;
  entry_t               w_head;
  logic [c_entry_w-1:0] w_rdata;
  logic                 w_cmd;
  logic                 w_push;
  logic                 w_pop;

  // Byte decode: address/MSB bytes only update the latch; anything else
  // becomes a queued command.
  always_comb begin
    w_cmd        = iByteValid && !iByte[c_op_addr_bit];
    w_push_entry = '0;
    if (iByte[c_op_delay_bit]) begin
      w_push_entry.etype = ENT_DELAY;
      w_push_entry.data  = {2'b00, iByte[5:0]};
    end else begin
      w_push_entry.etype = ENT_WRITE;
      w_push_entry.addr  = r_lat_addr;
      w_push_entry.data  = {r_lat_msb, iByte[5:0]};
    end
  end

  // Flush takes priority over both queue operations.
  assign w_push = w_cmd && !iFlush;
  assign w_pop  = clkEn && (r_state == ST_IDLE) && !oEmpty && !iFlush;
  assign w_head = entry_t'(w_rdata);
  assign oBusy  = !oEmpty || (r_state == ST_WAIT);

  sid_cmd_fifo #(
    .WIDTH (c_entry_w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstN  (rstN),
    .push  (w_push),
    .wdata (w_push_entry),
    .pop   (w_pop),
    .flush (iFlush),
    .rdata (w_rdata),
    .level (oLevel),
    .full  (oFull),
    .empty (oEmpty)
  );

  // Address/MSB latch survives writes and flushes.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_lat_addr <= '0;
      r_lat_msb  <= '0;
    end else if (iByteValid && iByte[c_op_addr_bit]) begin
      r_lat_addr <= iByte[6:2];
      r_lat_msb  <= iByte[1:0];
    end
  end

  // Sticky overflow; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      oOverflow <= 1'b0;
    end else if (w_push && oFull && !w_pop) begin
      oOverflow <= 1'b1;
    end else if (iClrOvf) begin
      oOverflow <= 1'b0;
    end
  end

  // Replay FSM. A write popped on a tick strobes oWE in the following clk;
  // the tick that ends a WAIT does not pop, so the next command goes out
  // one tick later.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      oWE     <= 1'b0;
      oAddr   <= '0;
      oDataW  <= '0;
    end else begin
      oWE <= 1'b0;
      if (iFlush) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_pop) begin
              if (w_head.etype == ENT_WRITE) begin
                oAddr  <= w_head.addr;
                oDataW <= w_head.data;
                oWE    <= 1'b1;
              end else begin
                r_cnt   <= CNT_W'((int'(w_head.data[5:0]) + 1) * DELAY_UNIT);
                r_state <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            if (clkEn) begin
              r_cnt <= r_cnt - CNT_W'(1);
              if (r_cnt == CNT_W'(1)) begin
                r_state <= ST_IDLE;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule : sid_write_sched
`default_nettype wire

// File: tb/tb_sid_write_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_sid_write_sched                                        |
// | Purpose  : Self-checking bench for sid_write_sched. Expected SID      |
// |            writes go into a scoreboard queue as bytes are sent and   |
// |            are matched against each oWE strobe.                      |
// | Ports    : none (top-level bench)                                    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_sid_write_sched;

  localparam int DEPTH      = 16;
  localparam int DELAY_UNIT = 4;
  localparam int CNT_W      = 13;

  logic       clk = 1'b0;
  logic       rstN;
  logic       clkEn;
  logic [7:0] iByte;
  logic       iByteValid;
  logic       iFlush;
  logic       iClrOvf;
  logic       oWE;
  logic [4:0] oAddr;
  logic [7:0] oDataW;
  logic [4:0] oLevel;
  logic       oFull;
  logic       oEmpty;
  logic       oOverflow;
  logic       oBusy;

  sid_write_sched #(
    .DEPTH      (DEPTH),
    .DELAY_UNIT (DELAY_UNIT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rstN       (rstN),
    .clkEn      (clkEn),
    .iByte      (iByte),
    .iByteValid (iByteValid),
    .iFlush     (iFlush),
    .iClrOvf    (iClrOvf),
    .oWE        (oWE),
    .oAddr      (oAddr),
    .oDataW     (oDataW),
    .oLevel     (oLevel),
    .oFull      (oFull),
    .oEmpty     (oEmpty),
    .oOverflow  (oOverflow),
    .oBusy      (oBusy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] a;
    logic [7:0] d;
  } exp_t;

  typedef struct {
    logic       has_addr;
    logic [7:0] ab;
    logic [7:0] lb;
    logic [4:0] ea;
    logic [7:0] ed;
  } vec_t;

  exp_t sb[$];
  int   we_ticks[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   we_count = 0;
  int   tick_no  = 0;
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: each strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (oWE) begin
      we_count++;
      we_ticks.push_back(tick_no);
      if (sb.size() == 0) begin
        chk("we_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("we_addr", {27'd0, oAddr}, {27'd0, mon_e.a});
        chk("we_data", {24'd0, oDataW}, {24'd0, mon_e.d});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    iByte      = b;
    iByteValid = 1'b1;
    cyc();
    iByteValid = 1'b0;
  endtask

  task automatic tick();
    tick_no++;
    clkEn = 1'b1;
    cyc();
    clkEn = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      cyc();
    end
  endtask

  task automatic wait_writes(input int target, input int budget);
    int k;
    k = 0;
    while (we_count < target && k < budget) begin
      tick();
      cyc();
      k++;
    end
    chk("writes_seen", we_count, target);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},    {31'd0, oWE},       32'd0);
    chk({tag, "_addr"},  {27'd0, oAddr},     32'd0);
    chk({tag, "_data"},  {24'd0, oDataW},    32'd0);
    chk({tag, "_level"}, {27'd0, oLevel},    32'd0);
    chk({tag, "_full"},  {31'd0, oFull},     32'd0);
    chk({tag, "_empty"}, {31'd0, oEmpty},    32'd1);
    chk({tag, "_ovf"},   {31'd0, oOverflow}, 32'd0);
    chk({tag, "_busy"},  {31'd0, oBusy},     32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    int   base;
    logic busy_bad;

    vt[0] = '{1'b1, 8'h8B, 8'h15, 5'd2,  8'hD5};
    vt[1] = '{1'b1, 8'hFC, 8'h00, 5'd31, 8'h00};
    vt[2] = '{1'b1, 8'h80, 8'h3F, 5'd0,  8'h3F};
    vt[3] = '{1'b1, 8'hFF, 8'h3F, 5'd31, 8'hFF};
    vt[4] = '{1'b1, 8'hA6, 8'h2A, 5'd9,  8'hAA};
    vt[5] = '{1'b1, 8'hC1, 8'h01, 5'd16, 8'h41};
    vt[6] = '{1'b0, 8'h00, 8'h05, 5'd16, 8'h45};  // latch persists

    rstN = 1'b0; clkEn = 1'b0; iByte = 8'h00; iByteValid = 1'b0;
    iFlush = 1'b0; iClrOvf = 1'b0;
    repeat (3) cyc();
    chk_reset_vals("por");
    @(negedge clk);
    rstN = 1'b1;
    cyc();

    // Single writes through the decoder.
    for (int i = 0; i < 7; i++) begin
      base = we_count;
      if (vt[i].has_addr) send(vt[i].ab);
      send(vt[i].lb);
      sb.push_back('{vt[i].ea, vt[i].ed});
      chk("vec_level_q", {27'd0, oLevel}, 32'd1);
      tick();
      cyc();
      chk("vec_we_count", we_count, base + 1);
      chk("vec_level_0", {27'd0, oLevel}, 32'd0);
    end

    // Burst of four writes inside one SID cycle.
    base = we_count;
    send(8'h80); send(8'h01); sb.push_back('{5'd0,  8'h01});
    send(8'h85); send(8'h02); sb.push_back('{5'd1,  8'h42});
    send(8'hCA); send(8'h33); sb.push_back('{5'd18, 8'hB3});
    send(8'hF7); send(8'h3C); sb.push_back('{5'd29, 8'hFC});
    chk("burst_level", {27'd0, oLevel}, 32'd4);
    we_ticks.delete();
    wait_writes(base + 4, 10);
    run_ticks(4);
    chk("burst_no_extra", we_count, base + 4);
    if (we_ticks.size() == 4)
      chk("burst_consecutive", we_ticks[3] - we_ticks[0], 32'd3);
    else
      chk("burst_tick_count", we_ticks.size(), 32'd4);

    // WRITE, DELAY N=2, WRITE: 14 ticks apart with DELAY_UNIT=4.
    base = we_count;
    busy_bad = 1'b0;
    we_ticks.delete();
    send(8'h8B); send(8'h15); sb.push_back('{5'd2, 8'hD5});
    send(8'h42);
    send(8'h15); sb.push_back('{5'd2, 8'hD5});
    for (int k = 0; k < 40 && we_count < base + 2; k++) begin
      tick();
      cyc();
      if (we_count > base && we_count < base + 2 && !oBusy) busy_bad = 1'b1;
    end
    chk("delay_writes", we_count, base + 2);
    if (we_ticks.size() == 2)
      chk("delay_spacing", we_ticks[1] - we_ticks[0], 32'd14);
    else
      chk("delay_tick_count", we_ticks.size(), 32'd2);
    chk("delay_busy_held", {31'd0, busy_bad}, 32'd0);
    chk("delay_idle_busy", {31'd0, oBusy}, 32'd0);

    // Fill with clkEn low, then overflow handling.
    base = we_count;
    send(8'h84);
    for (int i = 0; i < 16; i++) begin
      send(8'(i));
      sb.push_back('{5'd1, 8'(i)});
    end
    chk("full_flag", {31'd0, oFull}, 32'd1);
    chk("full_level", {27'd0, oLevel}, 32'd16);
    chk("full_no_ovf", {31'd0, oOverflow}, 32'd0);
    send(8'h3E);
    chk("ovf_set", {31'd0, oOverflow}, 32'd1);
    chk("ovf_level", {27'd0, oLevel}, 32'd16);
    iClrOvf = 1'b1;
    send(8'h3D);
    iClrOvf = 1'b0;
    chk("ovf_set_beats_clr", {31'd0, oOverflow}, 32'd1);
    iClrOvf = 1'b1;
    cyc();
    iClrOvf = 1'b0;
    chk("ovf_cleared", {31'd0, oOverflow}, 32'd0);
    // Push on full with a same-clock pop is accepted.
    tick_no++;
    clkEn = 1'b1; iByte = 8'h30; iByteValid = 1'b1;
    cyc();
    clkEn = 1'b0; iByteValid = 1'b0;
    sb.push_back('{5'd1, 8'h30});
    chk("fullpop_level", {27'd0, oLevel}, 32'd16);
    chk("fullpop_no_ovf", {31'd0, oOverflow}, 32'd0);
    wait_writes(base + 17, 40);
    chk("drain_empty", {31'd0, oEmpty}, 32'd1);

    // Flush with five queued entries and an active WAIT.
    send(8'h94);
    send(8'h45);
    for (int i = 1; i <= 5; i++) send(8'(i));
    tick();
    cyc();
    chk("pre_flush_busy", {31'd0, oBusy}, 32'd1);
    chk("pre_flush_level", {27'd0, oLevel}, 32'd5);
    iFlush = 1'b1; iByte = 8'h11; iByteValid = 1'b1;
    cyc();
    iFlush = 1'b0; iByteValid = 1'b0;
    chk("flush_empty", {31'd0, oEmpty}, 32'd1);
    chk("flush_busy", {31'd0, oBusy}, 32'd0);
    chk("flush_level", {27'd0, oLevel}, 32'd0);
    base = we_count;
    run_ticks(30);
    chk("flush_no_we", we_count, base);
    send(8'h3F);
    sb.push_back('{5'd5, 8'h3F});
    wait_writes(base + 1, 4);

    // Asynchronous reset mid-WAIT with three entries queued.
    send(8'h88);
    send(8'h40);
    send(8'h21); send(8'h22); send(8'h23);
    tick();
    cyc();
    chk("pre_rst_level", {27'd0, oLevel}, 32'd3);
    #3;
    rstN = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rstN = 1'b1;
    cyc();
    base = we_count;
    run_ticks(20);
    chk("rst_no_we", we_count, base);
    send(8'h01);
    sb.push_back('{5'd0, 8'h01});
    wait_writes(base + 1, 4);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule : tb_sid_write_sched
`default_nettype wire
